// File: rtl/seg7_scan_driver.sv
// Multiplexed four-digit seven-segment driver with blanking gaps between digits.
// All outputs are registered; inputs are snapshotted once per frame at the index-0 SCAN entry.
module seg7_scan_driver #(
    parameter int unsigned DIV = 50000,
    parameter int unsigned GAP = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic [3:0] thousands,
    input  logic       lzb,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       frame_done
);

    localparam int unsigned MaxDwell = (DIV > GAP) ? DIV : GAP;
    localparam int unsigned CntW     = (MaxDwell > 2) ? $clog2(MaxDwell) : 1;

    localparam logic [CntW-1:0] GapLast = CntW'(GAP - 1);
    localparam logic [CntW-1:0] DivLast = CntW'(DIV - 1);

    typedef enum logic [0:0] {
        StGap,
        StScan
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [15:0]     snap_q, snap_d;
    logic            snap_lzb_q, snap_lzb_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            fd_q, fd_d;

    logic [3:0]      digit;
    logic            blank;

    // Active-low cathodes {g,f,e,d,c,b,a}; non-BCD codes render dark.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        idx_d      = idx_q;
        snap_d     = snap_q;
        snap_lzb_d = snap_lzb_q;
        fd_d       = 1'b0;

        case (state_q)
            StGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StScan;
                    cnt_d   = '0;
                    if (idx_q == 2'd0) begin
                        snap_d     = {thousands, hundreds, tens, ones};
                        snap_lzb_d = lzb;
                    end
                end
            end
            StScan: begin
                if (cnt_q == DivLast) begin
                    state_d = StGap;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                    fd_d    = (idx_q == 2'd3);
                end
            end
            default: begin
                state_d = StGap;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are derived from next-state values so the registered pins track state_q exactly.
    always_comb begin
        digit = snap_d[{idx_d, 2'b00} +: 4];
        blank = 1'b0;
        if (snap_lzb_d) begin
            case (idx_d)
                2'd3:    blank = (snap_d[15:12] == 4'd0);
                2'd2:    blank = (snap_d[15:8] == 8'd0);
                2'd1:    blank = (snap_d[15:4] == 12'd0);
                default: blank = 1'b0;
            endcase
        end

        an_d  = 4'b1111;
        seg_d = 7'b1111111;
        if (state_d == StScan && !blank) begin
            an_d  = ~(4'b0001 << idx_d);
            seg_d = decode(digit);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StGap;
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            snap_q     <= '0;
            snap_lzb_q <= 1'b0;
            an_q       <= 4'b1111;
            seg_q      <= 7'b1111111;
            fd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            snap_q     <= snap_d;
            snap_lzb_q <= snap_lzb_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            fd_q       <= fd_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = fd_q;

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter DIV, default 50000, SHALL set the clock cycles each digit is lit (SCAN dwell); legal range >=2.
REQ-002 Parameter GAP, default 16, SHALL set the clock cycles all anodes are off between digits (anti-ghost blank); legal range >=1.
REQ-003 Port clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 Port rst  input  1  SHALL be the reset; it is synchronous and active-high.
REQ-005 Port ones  input  4  SHALL carry the BCD digit for position 0 (rightmost).
REQ-006 Port tens  input  4  SHALL carry the BCD digit for position 1.
REQ-007 Port hundreds  input  4  SHALL carry the BCD digit for position 2.
REQ-008 Port thousands  input  4  SHALL carry the BCD digit for position 3 (leftmost).
REQ-009 Port lzb  input  1  SHALL enable leading-zero blanking when 1.
REQ-010 Port an  output  4  SHALL be the active-low anode enables; an[i] drives position i.
REQ-011 Port seg  output  7  SHALL be the active-low cathodes, ordered {g,f,e,d,c,b,a}.
REQ-012 Port frame_done  output  1  SHALL pulse high for one cycle at the end of each complete 4-digit frame.

Function
REQ-013 The block SHALL be a two-state FSM: GAP (an=4'b1111, seg=7'b1111111) and SCAN (one digit driven); all outputs SHALL be registered.
REQ-014 GAP SHALL last exactly GAP cycles and SCAN exactly DIV cycles, counted by one dwell counter cleared on each state change.
REQ-015 A 2-bit digit index SHALL select the position; it SHALL advance modulo 4 (3 wraps to 0) on each SCAN->GAP transition.
REQ-016 On each GAP->SCAN transition with index 0, the four inputs and lzb SHALL be captured into snapshot registers; changes to inputs at any other time SHALL NOT affect the frame in progress.
REQ-017 In SCAN, an SHALL have only bit [index] low and seg SHALL be decode(snapshot[index]), unless that digit is blanked.
REQ-018 decode SHALL map 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000; values 10-15 SHALL give 1111111.
REQ-019 With captured lzb=1: thousands SHALL be blanked if 0; hundreds if it and thousands are 0; tens if it, hundreds and thousands are 0; ones SHALL never be blanked.
REQ-020 A blanked digit SHALL keep its SCAN slot timing but drive an=4'b1111 and seg=7'b1111111.
REQ-021 frame_done SHALL be high exactly in the first GAP cycle following the SCAN of index 3.
REQ-022 Frame period SHALL be 4*(DIV+GAP) cycles.

Reset
REQ-023 While rst=1 at a rising edge: state<=GAP, dwell counter<=0, index<=0, snapshots<=0, snapshot lzb<=0, an<=4'b1111, seg<=7'b1111111, frame_done<=0.
REQ-024 rst asserted mid-SCAN or mid-GAP SHALL abort the frame; after release the first GAP of GAP cycles precedes a fresh capture and index-0 SCAN.

Verification
REQ-025 DIV=4, GAP=2, inputs 1,2,3,4 (thousands..ones), lzb=0, release rst -> an=1111 for 2 cycles, 1110 seg=0011001 for 4, 1111 for 2, 1101 seg=0110000 for 4, ..., 0111 seg=1111001 for 4, then frame_done=1 for 1 cycle; repeat every 24 cycles.
REQ-026 Inputs 0,0,0,7, lzb=1 -> positions 3..1 show an=1111 during their slots, position 0 shows an=1110 seg=1111000; with lzb=0 all four slots show 1000000 except position 0.
REQ-027 Change ones from 4 to 9 during the index-2 SCAN -> current frame still shows 4 at position 0; next frame shows 0010000.
REQ-028 Any digit =12 -> that slot drives seg=1111111 with its anode low (lzb=0).
REQ-029 Assert rst for 1 cycle mid-SCAN of index 2 -> next cycle an=1111, seg=1111111, frame_done=0; index-0 SCAN begins exactly GAP cycles after release.
REQ-030 Inputs all 0, lzb=1 -> only position 0 lights, showing 1000000, every frame.
